ex_wb_stage: RTL and testbench
==============================

Name: ex_wb_stage

Overview:
- Pipeline register between the execute-stage shifter/ALU outputs and the register-file writeback port of the 16-bit CPU.
- Captures the result, destination register, write enable and shifted-out bit with a valid/ready handshake.
- Holds a 2-entry skid buffer so that `in_ready` is fully registered.
- Computes Z/N/C flags, maintains the architectural status register, and exposes a forwarding path for hazard bypass.

Parameters:
DATA_W, 16, datapath width of result and forwarding data
REG_ADDR_W, 4, destination register index width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  execute stage presents a result
in_ready  output  1  stage can accept; registered, not combinational from out_ready
in_result  input  DATA_W  execute-stage result (e.g. arithmetic-shift output)
in_rd  input  REG_ADDR_W  destination register index
in_we  input  1  result is to be written to the register file
in_flag_en  input  1  instruction updates the status register
in_cout  input  1  carry / last bit shifted out by the execute unit
out_valid  output  1  head entry valid toward writeback
out_ready  input  1  writeback accepts head entry
out_result  output  DATA_W  head entry result
out_rd  output  REG_ADDR_W  head entry destination
out_we  output  1  head entry write enable; gated by out_valid
fwd_valid  output  1  out_valid & out_we
fwd_rd  output  REG_ADDR_W  equals out_rd
fwd_data  output  DATA_W  equals out_result
status  output  3  architectural flags {N,Z,C}

Behaviour:
- Reset (rst=1 at a clk edge):
  - Both entries invalid; out_valid=0, in_ready=1, fwd_valid=0, status=3'b000.
  - Data/rd outputs are zeroed.
  - Reset mid-transfer drops any held entries without writeback or status update.
- Entry format: {result, rd, we, flag_en, Z, N, C}.
  - Flags are computed at capture: Z = (in_result == 0), N = in_result[DATA_W-1], C = in_cout.
- Storage is a main (head) register plus a skid register; occupancy count is 0, 1 or 2.
- Accept condition is in_valid & in_ready. Pop condition is out_valid & out_ready.
- in_ready = (count < 2), registered, and derived from next-state count.
- Transitions per cycle:
  - count 0, accept: load into head; count becomes 1.
  - count 1, accept and no pop: load into skid; count becomes 2.
  - count 1, accept and pop: load into head; count stays 1.
  - count 1, pop only: count becomes 0.
  - count 2, pop: skid moves to head; count becomes 1. Accept is impossible because in_ready=0.
- out_valid = (count != 0). Head contents remain stable while out_valid=1 and out_ready=0.
- Latency: a result accepted at edge k appears on outputs after edge k (registered, 1 cycle) when the buffer was empty or draining.
- Throughput: 1 entry/cycle with out_ready held high.
- Status register:
  - Updated on the pop edge with the head entry's {N,Z,C} when its flag_en=1; otherwise held.
  - Pops with flag_en=0 leave status unchanged.
  - in_we has no effect on flags.
- Forwarding reflects the head entry only; the skid entry is not forwarded. The hazard unit stalls on a skid hit.
- out_we=0 while out_valid=0. X on in_* while in_valid=0 must not propagate to any output or state.
- No combinational path from in_* to out_* or from out_ready to in_ready.

Test Plan:
- Reset then single transfer: in_result=16'h8000, in_rd=3, in_we=1, in_flag_en=1, in_cout=1, out_ready=1 -> next cycle out_valid=1, out_result=8000, out_rd=3, fwd_valid=1; after pop status={N=1,Z=0,C=1}.
- Back-pressure: out_ready=0, push A=0x0001 and B=0x0000 -> in_ready drops to 0 after the second accept; head stays A. Raise out_ready -> A then B emerge in order; the B pop sets Z=1 if its flag_en=1.
- Streaming: 8 consecutive pushes with out_ready=1 -> 8 pops on consecutive cycles, order preserved, in_ready constantly 1.
- Flag gating: pop entry with flag_en=0, result 0 -> status unchanged from prior value (e.g. 3'b101 retained).
- Reset mid-operation: buffer full (count 2), assert rst one cycle -> out_valid=0, in_ready=1, status=000 next cycle; previously held entries never appear.
- Random valid/ready toggling for 2000 cycles against a reference queue model -> no loss, duplication or reorder; in_ready is never 1 when count=2.

Source files
------------

// File: rtl/ex_wb_stage.sv
// ex_wb_stage
//   Pipeline register between the execute-stage shifter/ALU and the register
//   file writeback port. A head register plus a skid register hold up to two
//   results. This lets in_ready be a flop driven from next-state occupancy,
//   so it never depends combinationally on out_ready. Z/N/C are computed when
//   a result is captured. They commit to the architectural status register
//   when the entry is popped, and only if that instruction enables flags.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid       execute stage presents a result
//   in_ready       stage can accept (registered)
//   in_result      execute result
//   in_rd          destination register index
//   in_we          register-file write enable for this result
//   in_flag_en     instruction updates the status register
//   in_cout        carry / last bit shifted out
//   out_valid      head entry valid toward writeback
//   out_ready      writeback accepts the head entry
//   out_result     head result (zero while empty)
//   out_rd         head destination (zero while empty)
//   out_we         head write enable, gated by out_valid
//   fwd_valid      head is valid and writes the register file
//   fwd_rd         bypass destination (= out_rd)
//   fwd_data       bypass data (= out_result)
//   status         architectural flags {N,Z,C}
module ex_wb_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_we,
    input  logic                  in_flag_en,
    input  logic                  in_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_we,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [2:0]            status
);

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  flagEn;
        logic                  z;
        logic                  n;
        logic                  c;
    } entry_t;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    entry_t     headQ, headNext;
    entry_t     skidQ, skidNext;
    entry_t     capEntry;
    logic [1:0] cntQ, cntNext;
    logic       inReadyQ;
    logic [2:0] statusQ, statusNext;
    logic       headValid;
    logic       accept;
    logic       pop;

    assign headValid = (cntQ != CNT_EMPTY);
    assign accept    = in_valid & inReadyQ;
    assign pop       = headValid & out_ready;

    // Flags are frozen at capture so the status update at pop time needs
    // no further arithmetic on the stored result.
    always_comb begin
        capEntry        = '0;
        capEntry.result = in_result;
        capEntry.rd     = in_rd;
        capEntry.we     = in_we;
        capEntry.flagEn = in_flag_en;
        capEntry.z      = (in_result == '0);
        capEntry.n      = in_result[DATA_W-1];
        capEntry.c      = in_cout;
    end

    // Occupancy / storage next state. Input fields only reach storage on an
    // accept, so undriven inputs while in_valid=0 never land in state.
    always_comb begin
        cntNext  = cntQ;
        headNext = headQ;
        skidNext = skidQ;
        case (cntQ)
            CNT_EMPTY: begin
                if (accept) begin
                    headNext = capEntry;
                    cntNext  = CNT_ONE;
                end
            end
            CNT_ONE: begin
                if (accept && !pop) begin
                    skidNext = capEntry;
                    cntNext  = CNT_FULL;
                end else if (accept && pop) begin
                    headNext = capEntry;
                end else if (pop) begin
                    cntNext = CNT_EMPTY;
                end
            end
            CNT_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    headNext = skidQ;
                    cntNext  = CNT_ONE;
                end
            end
            default: begin
                cntNext = CNT_EMPTY;
            end
        endcase
    end

    always_comb begin
        statusNext = statusQ;
        if (pop && headQ.flagEn) begin
            statusNext = {headQ.n, headQ.z, headQ.c};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            headQ    <= '0;
            skidQ    <= '0;
            cntQ     <= CNT_EMPTY;
            inReadyQ <= 1'b1;
            statusQ  <= 3'b000;
        end else begin
            headQ    <= headNext;
            skidQ    <= skidNext;
            cntQ     <= cntNext;
            inReadyQ <= (cntNext != CNT_FULL);
            statusQ  <= statusNext;
        end
    end

    // Outputs come from flops only; data is masked while empty so a stale
    // head never shows up on the writeback or bypass buses.
    assign in_ready   = inReadyQ;
    assign out_valid  = headValid;
    assign out_result = headValid ? headQ.result : '0;
    assign out_rd     = headValid ? headQ.rd : '0;
    assign out_we     = headValid & headQ.we;
    assign fwd_valid  = headValid & headQ.we;
    assign fwd_rd     = out_rd;
    assign fwd_data   = out_result;
    assign status     = statusQ;

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic [3:0]  in_rd = '0;
    logic        in_we = 1'b0;
    logic        in_flag_en = 1'b0;
    logic        in_cout = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [3:0]  out_rd;
    logic        out_we;
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [15:0] fwd_data;
    logic [2:0]  status;

    ex_wb_stage #(.DATA_W(16), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_rd(in_rd), .in_we(in_we),
        .in_flag_en(in_flag_en), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .status(status)
    );

    always #5 clk = ~clk;

    // Reference model: an in-order queue of capacity two; flags derived
    // directly from the result value and carry-in.
    typedef struct {
        logic [15:0] r;
        logic [3:0]  d;
        logic        we;
        logic        fe;
        logic        z;
        logic        n;
        logic        c;
    } ent_t;

    ent_t       q[$];
    logic [2:0] expStatus = 3'b000;
    int         pendAcc = 0;   // 1 when the back of q is accepted at the coming edge
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, applied just after a rising edge.
    task automatic step(input logic v, input logic [15:0] r, input logic [3:0] d,
                        input logic we, input logic fe, input logic co, input logic ordy);
        ent_t e;
        @(posedge clk);
        #1;
        in_valid   = v;
        in_result  = r;
        in_rd      = d;
        in_we      = we;
        in_flag_en = fe;
        in_cout    = co;
        out_ready  = ordy;
        pendAcc    = (v && in_ready) ? 1 : 0;
        if (pendAcc != 0) begin
            e.r = r; e.d = d; e.we = we; e.fe = fe;
            e.z = (r == 16'h0000);
            e.n = (r >= 16'h8000);
            e.c = co;
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ordy);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        pendAcc  = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        expStatus = 3'b000;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_status", status, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", out_rd, 0);
    endtask

    // Monitor: compares DUT outputs against the model each falling edge and
    // retires the head entry when a pop will happen at the next rising edge.
    always @(negedge clk) begin
        int occ;
        ent_t e;
        if (!rst) begin
            occ = q.size() - pendAcc;
            chk("in_ready", in_ready, (occ < 2) ? 1 : 0);
            chk("out_valid", out_valid, (occ != 0) ? 1 : 0);
            chk("status", status, expStatus);
            if (occ != 0) begin
                e = q[0];
                chk("out_result", out_result, e.r);
                chk("out_rd", out_rd, e.d);
                chk("out_we", out_we, e.we);
                chk("fwd_valid", fwd_valid, e.we);
                chk("fwd_rd", fwd_rd, e.d);
                chk("fwd_data", fwd_data, e.r);
                if (out_ready) begin
                    void'(q.pop_front());
                    if (e.fe) expStatus = {e.n, e.z, e.c};
                end
            end else begin
                chk("out_we_idle", out_we, 0);
                chk("fwd_valid_idle", fwd_valid, 0);
            end
        end
    end

    initial begin
        doReset();

        // Single transfer.
        step(1'b1, 16'h8000, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        #1;
        chk("single_status", status, 3'b101);

        // Back-pressure: A then B held, then drained in order.
        step(1'b1, 16'h0001, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_head_is_A", out_result, 16'h0001);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("bp_status_z", status, 3'b010);

        // Streaming: eight back-to-back pushes with writeback always ready.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'(16'h1000 * i + 3), 4'(i), 1'b1, 1'b0, 1'b0, 1'b1);
            chk("stream_in_ready", in_ready, 1);
        end
        idle(1'b1);
        idle(1'b1);
        chk("stream_drained", q.size(), 0);

        // Flag gating: establish 101, then pop a zero result with flag_en=0.
        step(1'b1, 16'hC000, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("gate_status_kept", status, 3'b101);

        // Reset with the buffer full.
        step(1'b1, 16'h1234, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h5678, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("full_before_rst", in_ready, 0);
        doReset();
        idle(1'b1);
        idle(1'b1);
        chk("after_rst_empty", out_valid, 0);
        chk("after_rst_status", status, 0);

        // Randomised valid/ready traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] r;
            r = (($urandom % 6) == 0) ? 16'h0000 : 16'($urandom);
            step(1'($urandom), r, 4'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), (($urandom % 4) != 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("random_drained", q.size(), 0);
        chk("random_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
